// File: rtl/ulx3s_clk_pkg.sv
// Shared clocking definitions: lock-monitor state encoding, default timing
// constants and the timer-width helper.
package ulx3s_clk_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      RUN       = 3'd2,
      LOST      = 3'd3,
      PLL_RST   = 3'd4
   } lock_state_t;

   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_TIMEOUT_CYCLES = 1048576;
   localparam int DEF_PLLRST_CYCLES  = 32;

   // One timer serves every state, so it is sized for the longest interval.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ulx3s_pll_lock_monitor.sv
// PLL lock supervisor: holds downstream logic in reset until lock has been
// stable long enough, and pulses the PLL reset when lock never arrives.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | downstream held in reset, timing out a missing lock
// STABLE    | lock seen, counting uninterrupted locked cycles
// RUN       | downstream released, ready high
// LOST      | one-cycle lock-loss bookkeeping, back to WAIT_LOCK
// PLL_RST   | pll_rst held high for the retry pulse
module ulx3s_pll_lock_monitor
   import ulx3s_clk_pkg::*;
#(
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int PLLRST_CYCLES  = DEF_PLLRST_CYCLES
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [7:0] loss_count,
   output logic [7:0] retry_count
);

   localparam int CW = cnt_width(STABLE_CYCLES, TIMEOUT_CYCLES, PLLRST_CYCLES);
   localparam logic [CW-1:0] TC_STABLE  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TC_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TC_PLLRST  = CW'(PLLRST_CYCLES - 1);

   logic          locked_s;
   lock_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          loss_inc, retry_inc;

   sync2 u_sync_lock (
      .clk   (clkin),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      loss_inc  = 1'b0;
      retry_inc = 1'b0;
      case (state)
         WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (locked_s) begin
               state_nxt = STABLE;
            end else if (cnt == TC_TIMEOUT) begin
               state_nxt = PLL_RST;
               retry_inc = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s)               state_nxt = WAIT_LOCK;
            else if (cnt == TC_STABLE)   state_nxt = RUN;
            else                         cnt_nxt   = cnt + 1'b1;
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = LOST;
               loss_inc  = 1'b1;
            end
         end
         LOST:    state_nxt = WAIT_LOCK;
         PLL_RST: begin
            if (cnt == TC_PLLRST) state_nxt = WAIT_LOCK;
            else                  cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Outputs decode the next state so they switch on the transition edge.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         sys_rst_n   <= 1'b0;
         ready       <= 1'b0;
         pll_rst     <= 1'b0;
         loss_count  <= 8'd0;
         retry_count <= 8'd0;
      end else begin
         sys_rst_n <= (state_nxt == RUN);
         ready     <= (state_nxt == RUN);
         pll_rst   <= (state_nxt == PLL_RST);
         if (loss_inc && (loss_count != 8'hFF))
            loss_count <= loss_count + 8'd1;
         if (retry_inc && (retry_count != 8'hFF))
            retry_count <= retry_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_ulx3s_pll_lock_monitor.sv
// Scoreboard bench for the PLL lock monitor: stimulus queues expected output
// events with their cycle numbers, a monitor matches every output change.
module tb_ulx3s_pll_lock_monitor;

   localparam int SC = 8;
   localparam int TC = 64;
   localparam int PC = 4;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst_n, ready;
   logic [7:0] loss_count, retry_count;

   ulx3s_pll_lock_monitor #(
      .STABLE_CYCLES  (SC),
      .TIMEOUT_CYCLES (TC),
      .PLLRST_CYCLES  (PC)
   ) dut (
      .clkin       (clkin),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .pll_rst     (pll_rst),
      .sys_rst_n   (sys_rst_n),
      .ready       (ready),
      .loss_count  (loss_count),
      .retry_count (retry_count)
   );

   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic       rdy;
      logic       prst;
      logic       srst;
      logic [7:0] loss;
      logic [7:0] retry;
   } ev_t;

   ev_t         exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [18:0] prev = '0;
   logic        e_rdy = 1'b0, e_prst = 1'b0, e_srst = 1'b0;
   int          e_loss = 0, e_retry = 0;

   task automatic expect_ev(input int at, input logic rdy, input logic prst,
                            input logic srst, input int loss, input int retry);
      ev_t e;
      e.at = at; e.rdy = rdy; e.prst = prst; e.srst = srst;
      e.loss = 8'(loss); e.retry = 8'(retry);
      exp_q.push_back(e);
      e_rdy = rdy; e_prst = prst; e_srst = srst; e_loss = loss; e_retry = retry;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clkin);
   endtask

   // Called at a falling edge; returns the cycle at which rst_n was released.
   task automatic do_reset(output int r);
      int n;
      n = cyc;
      pll_locked = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({ready, pll_rst, sys_rst_n, loss_count, retry_count} !== 19'd0) begin
         miscompares++;
         $display("FAIL async_reset cyc=%0d got rdy=%b pll_rst=%b sys_rst_n=%b loss=%0d retry=%0d, expected all zero",
                  cyc, ready, pll_rst, sys_rst_n, loss_count, retry_count);
      end
      if (e_rdy || e_prst || e_srst || e_loss != 0 || e_retry != 0)
         expect_ev(n + 1, 1'b0, 1'b0, 1'b0, 0, 0);
      wait_until(n + 3);
      rst_n = 1'b1;
      r = n + 3;
   endtask

   initial begin
      ev_t e;
      forever begin
         @(posedge clkin);
         #1;
         if ({ready, pll_rst, sys_rst_n, loss_count, retry_count} != prev) begin
            prev = {ready, pll_rst, sys_rst_n, loss_count, retry_count};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event cyc=%0d got rdy=%b pll_rst=%b sys_rst_n=%b loss=%0d retry=%0d, none expected",
                        cyc, ready, pll_rst, sys_rst_n, loss_count, retry_count);
            end else begin
               e = exp_q.pop_front();
               if (e.at != cyc || e.rdy !== ready || e.prst !== pll_rst ||
                   e.srst !== sys_rst_n || e.loss !== loss_count || e.retry !== retry_count) begin
                  miscompares++;
                  $display("FAIL event got cyc=%0d rdy=%b pll_rst=%b sys_rst_n=%b loss=%0d retry=%0d, expected cyc=%0d rdy=%b pll_rst=%b sys_rst_n=%b loss=%0d retry=%0d",
                           cyc, ready, pll_rst, sys_rst_n, loss_count, retry_count,
                           e.at, e.rdy, e.prst, e.srst, e.loss, e.retry);
               end
            end
         end
      end
   end

   initial begin
      int r, c;
      @(negedge clkin);
      do_reset(r);

      // Steady lock from r+10: 2 sync + 1 detect + 8 stable cycles.
      wait_until(r + 10);
      pll_locked = 1'b1;
      expect_ev(r + 21, 1'b1, 1'b0, 1'b1, 0, 0);

      // One-cycle drops from RUN; loss count saturates at 255.
      c = r + 25;
      for (int i = 0; i < 300; i++) begin
         wait_until(c);
         pll_locked = 1'b0;
         e_loss = (e_loss < 255) ? e_loss + 1 : 255;
         expect_ev(c + 3, 1'b0, 1'b0, 1'b0, e_loss, 0);
         wait_until(c + 1);
         pll_locked = 1'b1;
         expect_ev(c + 13, 1'b1, 1'b0, 1'b1, e_loss, 0);
         c += 14;
      end
      wait_until(c);
      do_reset(r);

      // Short 5-cycle lock blip restarts the timeout, then a retry, then lock.
      wait_until(r + 50);
      pll_locked = 1'b1;
      wait_until(r + 55);
      pll_locked = 1'b0;
      expect_ev(r + 122, 1'b0, 1'b1, 1'b0, 0, 1);
      expect_ev(r + 126, 1'b0, 1'b0, 1'b0, 0, 1);
      wait_until(r + 130);
      pll_locked = 1'b1;
      expect_ev(r + 141, 1'b1, 1'b0, 1'b1, 0, 1);
      wait_until(r + 145);
      do_reset(r);

      // No lock at all: 4-cycle pll_rst pulses every 68 cycles.
      for (int k = 0; k < 3; k++) begin
         expect_ev(r + 64 + 68 * k, 1'b0, 1'b1, 1'b0, 0, k + 1);
         expect_ev(r + 68 + 68 * k, 1'b0, 1'b0, 1'b0, 0, k + 1);
      end
      expect_ev(r + 268, 1'b0, 1'b1, 1'b0, 0, 4);
      // Reset in the second cycle of the fourth pulse truncates it.
      wait_until(r + 269);
      do_reset(r);
      expect_ev(r + 64, 1'b0, 1'b1, 1'b0, 0, 1);
      expect_ev(r + 68, 1'b0, 1'b0, 1'b0, 0, 1);
      wait_until(r + 75);

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clkin);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_events got %0d still pending, expected 0 (next at cyc=%0d)",
                  exp_q.size(), exp_q[0].at);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
